// File: rtl/counter_bank_if.sv
// counter_bank_if: control, status and snapshot stream signals of a counter bank
interface counter_bank_if #(
  parameter int WIDTH = 8,
  parameter int NCHAN = 4,
  parameter int CHW   = 2
);
  logic [NCHAN-1:0]       en, dir, load, clr_ovf, tc, ovf;
  logic [NCHAN*WIDTH-1:0] load_val, count;
  logic                   snap_req, busy, rd_valid, rd_ready;
  logic [CHW-1:0]         rd_chan;
  logic [WIDTH-1:0]       rd_data;
  modport master (
    output en, dir, load, load_val, clr_ovf, snap_req, rd_ready,
    input  count, tc, ovf, busy, rd_valid, rd_chan, rd_data
  );
  modport slave (
    input  en, dir, load, load_val, clr_ovf, snap_req, rd_ready,
    output count, tc, ovf, busy, rd_valid, rd_chan, rd_data
  );
endinterface

// File: rtl/counter_bank.sv
// counter_bank: NCHAN up/down counters with wrap/saturate, tc/ovf flags and a snapshot stream
module counter_bank #(
  parameter int WIDTH = 8,
  parameter int NCHAN = 4,
  parameter int SAT   = 0,
  parameter int CHW   = 2
) (
  input logic           clk,
  input logic           rst,
  counter_bank_if.slave bus
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [CHW-1:0]   LAST = CHW'(NCHAN - 1);
  logic [NCHAN-1:0][WIDTH-1:0] cnt_q, cnt_d, shd_q, shd_d;
  logic [NCHAN-1:0]            hit, tc_q, ovf_q, ovf_d;
  logic [CHW-1:0]              chan_q, chan_d;
  state_t                      state_q, state_d;
  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    // a boundary hit only counts when a load does not take priority
    assign hit[c] = !bus.load[c] && bus.en[c] &&
                    (bus.dir[c] ? cnt_q[c] == MAX : cnt_q[c] == '0);
    assign cnt_d[c] = bus.load[c] ? bus.load_val[c*WIDTH +: WIDTH] :
                      !bus.en[c] || (hit[c] && SAT != 0) ? cnt_q[c] :
                      bus.dir[c] ? cnt_q[c] + WIDTH'(1) : cnt_q[c] - WIDTH'(1);
  end
  assign ovf_d     = hit | (ovf_q & ~bus.clr_ovf);
  assign bus.count = cnt_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tc_q    <= '0;
      ovf_q   <= '0;
      shd_q   <= '0;
      chan_q  <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= hit;
      ovf_q   <= ovf_d;
      shd_q   <= shd_d;
      chan_q  <= chan_d;
      state_q <= state_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (bus.snap_req ? SEND : IDLE) :
              (bus.rd_ready && chan_q == LAST ? IDLE : SEND);
    chan_d  = state_q == SEND && !bus.rd_ready ? chan_q :
              state_q == SEND && chan_q != LAST ? chan_q + CHW'(1) : '0;
    shd_d   = state_q == IDLE && bus.snap_req ? cnt_q : shd_q;
  end
  always_comb begin
    bus.busy     = state_q == SEND;
    bus.rd_valid = state_q == SEND;
    bus.rd_chan  = chan_q;
    bus.rd_data  = shd_q[chan_q];
  end
endmodule
